// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer and its environment: instruction handshake,
// register-file read/write ports, ALU operand/result lines and status pulses.
interface alu_sequencer_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;

    logic [REG_ADDR_W-1:0] rf_raddr_a;
    logic [REG_ADDR_W-1:0] rf_raddr_b;
    logic [31:0]           rf_rdata_a;
    logic [31:0]           rf_rdata_b;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [31:0]           rf_wdata;

    logic [31:0]           alu_operand_a;
    logic [31:0]           alu_operand_b;
    logic [4:0]            alu_control;
    logic [31:0]           alu_result;
    logic                  alu_zero;

    logic                  done;
    logic                  zero_flag;
    logic                  illegal_op;
    logic                  div_by_zero;

    modport master (
        input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_result, alu_zero,
        output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_operand_a, alu_operand_b, alu_control,
               done, zero_flag, illegal_op, div_by_zero
    );

    modport slave (
        output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_result, alu_zero,
        input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_operand_a, alu_operand_b, alu_control,
               done, zero_flag, illegal_op, div_by_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state execute controller: fetches operands from a sync-read register file,
// drives a combinational ALU, and writes the result back with a fixed 3-cycle latency.
module alu_sequencer #(
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b00100;
    localparam logic [4:0] OP_DIV  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_XOR  = 5'b01000;
    localparam logic [4:0] OP_XORI = 5'b01001;
    localparam logic [4:0] OP_SLL  = 5'b01010;
    localparam logic [4:0] OP_SRL  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100;
    localparam logic [4:0] OP_SLT  = 5'b10100;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_MUL, OP_DIV, OP_AND, OP_OR,
            OP_XOR, OP_XORI, OP_SLL, OP_SRL, OP_SRA, OP_SLT: op_legal = 1'b1;
            default:                                         op_legal = 1'b0;
        endcase
    endfunction

    state_t                state;
    logic [4:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [IMM_W-1:0]      imm_q;
    logic                  legal_q;
    logic [31:0]           result_q;
    logic                  zero_q;

    logic [REG_ADDR_W-1:0] raddr_a_q;
    logic [REG_ADDR_W-1:0] raddr_b_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic                  we_q;
    logic [4:0]            ctrl_q;
    logic                  done_q;
    logic                  zero_flag_q;
    logic                  illegal_q;
    logic                  div_zero_q;

    logic [31:0]           imm_ext;
    logic [31:0]           operand_a;
    logic [31:0]           operand_b;

    assign imm_ext = {{(32-IMM_W){imm_q[IMM_W-1]}}, imm_q};

    // NOTE: every variable gets a default before the conditional path, so no latch is inferred.
    always_comb begin
        operand_a = '0;
        operand_b = '0;
        if (state == S_EXECUTE) begin
            operand_a = bus.rf_rdata_a;
            operand_b = (op_q == OP_ADDI || op_q == OP_XORI) ? imm_ext : bus.rf_rdata_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= OP_NOP;
            rd_q        <= '0;
            imm_q       <= '0;
            legal_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            raddr_a_q   <= '0;
            raddr_b_q   <= '0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            ctrl_q      <= OP_NOP;
            done_q      <= 1'b0;
            zero_flag_q <= 1'b0;
            illegal_q   <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make the status strobes single-cycle pulses
            // that are only raised again by the EXECUTE branch below.
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            div_zero_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        op_q      <= bus.instr[31:27];
                        rd_q      <= bus.instr[26 -: REG_ADDR_W];
                        imm_q     <= bus.instr[IMM_W-1:0];
                        // Addresses go out during DECODE so read data lands in EXECUTE.
                        raddr_a_q <= bus.instr[21 -: REG_ADDR_W];
                        raddr_b_q <= bus.instr[16 -: REG_ADDR_W];
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    legal_q <= op_legal(op_q);
                    ctrl_q  <= op_legal(op_q) ? op_q : OP_NOP;
                    state   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    result_q   <= bus.alu_result;
                    zero_q     <= bus.alu_zero;
                    waddr_q    <= rd_q;
                    done_q     <= 1'b1;
                    we_q       <= legal_q && (op_q != OP_NOP) && (rd_q != '0);
                    illegal_q  <= !legal_q;
                    div_zero_q <= (op_q == OP_DIV) && (operand_b == '0);
                    state      <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (legal_q && (op_q != OP_NOP)) begin
                        zero_flag_q <= zero_q;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready   = (state == S_IDLE);
    assign bus.rf_raddr_a    = raddr_a_q;
    assign bus.rf_raddr_b    = raddr_b_q;
    assign bus.rf_we         = we_q;
    assign bus.rf_waddr      = waddr_q;
    assign bus.rf_wdata      = result_q;
    assign bus.alu_operand_a = operand_a;
    assign bus.alu_operand_b = operand_b;
    assign bus.alu_control   = ctrl_q;
    assign bus.done          = done_q;
    assign bus.zero_flag     = zero_flag_q;
    assign bus.illegal_op    = illegal_q;
    assign bus.div_by_zero   = div_zero_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural register file and ALU around the DUT, an
// instruction-level reference model checked every cycle, plus hand-computed vectors.
module tb_alu_sequencer;
    localparam logic [4:0] ADD  = 5'b00001, SUB = 5'b00010, ADDI = 5'b00011;
    localparam logic [4:0] MUL  = 5'b00100, DIV = 5'b00101, AND_ = 5'b00110;
    localparam logic [4:0] OR_  = 5'b00111, XOR_ = 5'b01000, XORI = 5'b01001;
    localparam logic [4:0] SLL  = 5'b01010, SRL = 5'b01011, SRA = 5'b01100;
    localparam logic [4:0] SLT  = 5'b10100, NOP = 5'b00000;

    logic clk = 1'b0;
    logic rst_n;

    alu_sequencer_if #(.REG_ADDR_W(5)) bus ();

    alu_sequencer #(.REG_ADDR_W(5), .IMM_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference ALU semantics (DIV is unsigned; divide by zero yields all ones).
    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ADD, ADDI:  return a + b;
            SUB:        return a - b;
            MUL:        return a * b;
            DIV:        return (b == 0) ? 32'hFFFF_FFFF : a / b;
            AND_:       return a & b;
            OR_:        return a | b;
            XOR_, XORI: return a ^ b;
            SLL:        return a << b[4:0];
            SRL:        return a >> b[4:0];
            SRA:        return $signed(a) >>> b[4:0];
            SLT:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:    return 32'd0;
        endcase
    endfunction

    // Environment: the ALU the sequencer drives, and a synchronous-read register file.
    always_comb begin
        bus.alu_result = alu_ref(bus.alu_control, bus.alu_operand_a, bus.alu_operand_b);
        bus.alu_zero   = (bus.alu_result == 32'd0);
    end

    logic [31:0] rf_mem [0:31] = '{default: '0};
    always @(posedge clk) begin
        bus.rf_rdata_a <= rf_mem[bus.rf_raddr_a];
        bus.rf_rdata_b <= rf_mem[bus.rf_raddr_b];
        if (bus.rf_we) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
    end

    // Instruction-level model: what each accepted instruction must produce.
    typedef struct {
        logic [4:0]  op;
        logic [4:0]  ctrl;
        logic [4:0]  rd;
        logic        legal;
        logic        we;
        logic        dz;
        logic        zero;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] res;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ill;
        logic        dz;
    } done_rec_t;

    logic [31:0] m_rf [0:31] = '{default: '0};
    exp_t        m;
    int          m_phase = 0;   // cycles since acceptance, 0 when idle
    logic        m_zf    = 1'b0;
    int          cyc     = 0;
    int          acc_cnt = 0;
    int          acc_log [$];
    done_rec_t   done_log [$];
    int          done_cnt = 0;
    logic [31:0] last_opb;
    logic [4:0]  last_ctrl;

    function automatic exp_t predict(input logic [31:0] w);
        exp_t e;
        logic [4:0] op;
        op      = w[31:27];
        e.op    = op;
        e.rd    = w[26:22];
        e.legal = op inside {NOP, ADD, SUB, ADDI, MUL, DIV, AND_, OR_, XOR_, XORI, SLL, SRL, SRA, SLT};
        e.ctrl  = e.legal ? op : NOP;
        e.opa   = m_rf[w[21:17]];
        e.opb   = (op == ADDI || op == XORI) ? {{20{w[11]}}, w[11:0]} : m_rf[w[16:12]];
        e.res   = alu_ref(e.ctrl, e.opa, e.opb);
        e.zero  = (e.res == 32'd0);
        e.we    = e.legal && (op != NOP) && (e.rd != 5'd0);
        e.dz    = (op == DIV) && (e.opb == 32'd0);
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_zf    <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (m_phase == 0) begin
                if (bus.instr_valid) begin
                    m       <= predict(bus.instr);
                    m_phase <= 1;
                    acc_cnt <= acc_cnt + 1;
                    acc_log.push_back(cyc);
                end
            end else if (m_phase == 3) begin
                m_phase <= 0;
                if (m.we) m_rf[m.rd] <= m.res;
                if (m.legal && m.op != NOP) m_zf <= m.zero;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled just after the active edge.
    always begin
        @(posedge clk);
        #1;
        check("instr_ready", bus.instr_ready, m_phase == 0);
        check("done", bus.done, m_phase == 3);
        check("rf_we", bus.rf_we, m_phase == 3 && m.we);
        check("illegal_op", bus.illegal_op, m_phase == 3 && !m.legal);
        check("div_by_zero", bus.div_by_zero, m_phase == 3 && m.dz);
        check("zero_flag", bus.zero_flag, m_zf);
        if (m_phase == 2) begin
            check("alu_control", bus.alu_control, m.ctrl);
            check("alu_operand_a", bus.alu_operand_a, m.opa);
            check("alu_operand_b", bus.alu_operand_b, m.opb);
            last_opb  = bus.alu_operand_b;
            last_ctrl = bus.alu_control;
        end else begin
            check("alu_operand_a_idle", bus.alu_operand_a, 32'd0);
            check("alu_operand_b_idle", bus.alu_operand_b, 32'd0);
        end
        if (m_phase == 3 && m.we) begin
            check("rf_waddr", bus.rf_waddr, m.rd);
            check("rf_wdata", bus.rf_wdata, m.res);
        end
        if (bus.done) begin
            done_log.push_back('{cyc, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.illegal_op, bus.div_by_zero});
            done_cnt++;
        end
    end

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic wait_accept();
        int start;
        int n;
        start = acc_cnt;
        n = 0;
        while (acc_cnt == start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", n >= 20, 1'b0);
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        wait_accept();
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", n >= 20, 1'b0);
    endtask

    task automatic run(input logic [31:0] w);
        send(w);
        wait_done();
    endtask

    int          saved_done;
    int          na;
    int          nd;
    logic [31:0] vec_w [12];
    logic [31:0] vec_r [12];

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_instr_ready", bus.instr_ready, 1'b1);
        check("rst_outputs", {bus.done, bus.rf_we, bus.illegal_op, bus.div_by_zero, bus.zero_flag}, 5'd0);
        check("rst_addrs", {bus.rf_raddr_a, bus.rf_raddr_b, bus.rf_waddr, bus.alu_control}, 20'd0);
        check("rst_wdata", bus.rf_wdata, 32'd0);
        rst_n = 1'b1;

        // ADD r3 = r1 + r2 with r1=5, r2=7
        run(enc(ADDI, 5'd1, 5'd0, 5'd0, 12'd5));
        run(enc(ADDI, 5'd2, 5'd0, 5'd0, 12'd7));
        run(enc(ADD, 5'd3, 5'd1, 5'd2, 12'd0));
        check("add_wdata", done_log[$].wdata, 32'd12);
        check("add_waddr", done_log[$].waddr, 5'd3);
        check("add_we", done_log[$].we, 1'b1);
        check("add_latency", done_log[$].cyc - acc_log[$], 3);
        @(negedge clk);
        check("add_ready_t4", bus.instr_ready, 1'b1);
        check("add_zero_flag", bus.zero_flag, 1'b0);

        // ADDI with imm 0xFFF: operand b sign-extends, 1 + (-1) = 0
        run(enc(ADDI, 5'd1, 5'd0, 5'd0, 12'd1));
        run(enc(ADDI, 5'd4, 5'd1, 5'd0, 12'hFFF));
        check("addi_opb", last_opb, 32'hFFFF_FFFF);
        check("addi_wdata", done_log[$].wdata, 32'd0);
        @(negedge clk);
        check("addi_zero_flag", bus.zero_flag, 1'b1);

        // DIV by zero
        run(enc(ADDI, 5'd1, 5'd0, 5'd0, 12'd10));
        run(enc(ADDI, 5'd2, 5'd0, 5'd0, 12'd0));
        run(enc(DIV, 5'd5, 5'd1, 5'd2, 12'd0));
        check("div0_wdata", done_log[$].wdata, 32'hFFFF_FFFF);
        check("div0_flag", done_log[$].dz, 1'b1);
        check("div0_we", done_log[$].we, 1'b1);

        // Illegal opcode leaves zero_flag at 1
        run(enc(XORI, 5'd6, 5'd0, 5'd0, 12'd0));
        run(enc(5'b11111, 5'd7, 5'd1, 5'd2, 12'd0));
        check("ill_flag", done_log[$].ill, 1'b1);
        check("ill_we", done_log[$].we, 1'b0);
        check("ill_ctrl", last_ctrl, 5'd0);
        check("ill_latency", done_log[$].cyc - acc_log[$], 3);
        @(negedge clk);
        check("ill_zero_hold", bus.zero_flag, 1'b1);

        // SUB to r0, then ADD held valid back-to-back
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = enc(SUB, 5'd0, 5'd1, 5'd2, 12'd0);
        wait_accept();
        bus.instr = enc(ADD, 5'd7, 5'd1, 5'd2, 12'd0);
        wait_accept();
        bus.instr_valid = 1'b0;
        wait_done();
        na = acc_log.size();
        nd = done_log.size();
        check("b2b_accept_gap", acc_log[na-1] - acc_log[na-2], 4);
        check("b2b_sub_we", done_log[nd-2].we, 1'b0);
        check("b2b_sub_done_t3", done_log[nd-2].cyc - acc_log[na-2], 3);
        check("b2b_add_done_t7", done_log[nd-1].cyc - acc_log[na-2], 7);
        check("b2b_add_wdata", done_log[nd-1].wdata, 32'd10);

        // Reset during EXECUTE of an XOR
        saved_done = done_cnt;
        send(enc(XOR_, 5'd8, 5'd1, 5'd4, 12'd0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", bus.instr_ready, 1'b1);
        check("rst_mid_pulses", {bus.done, bus.rf_we, bus.illegal_op, bus.div_by_zero, bus.zero_flag}, 5'd0);
        check("rst_mid_ops", bus.alu_operand_a | bus.alu_operand_b, 32'd0);
        check("rst_mid_ctrl", bus.alu_control, 5'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid_no_done", done_cnt, saved_done);
        check("rst_mid_no_write", rf_mem[8], 32'd0);
        run(enc(ADD, 5'd9, 5'd1, 5'd2, 12'd0));
        check("post_rst_add", done_log[$].wdata, 32'd10);

        // Datapath sweep with r10 = -8, r11 = 3
        run(enc(ADDI, 5'd10, 5'd0, 5'd0, 12'hFF8));
        run(enc(ADDI, 5'd11, 5'd0, 5'd0, 12'd3));
        vec_w[0]  = enc(MUL,  5'd12, 5'd10, 5'd11, 12'd0);  vec_r[0]  = 32'hFFFF_FFE8;
        vec_w[1]  = enc(AND_, 5'd13, 5'd10, 5'd11, 12'd0);  vec_r[1]  = 32'h0000_0000;
        vec_w[2]  = enc(OR_,  5'd14, 5'd10, 5'd11, 12'd0);  vec_r[2]  = 32'hFFFF_FFFB;
        vec_w[3]  = enc(XOR_, 5'd15, 5'd10, 5'd11, 12'd0);  vec_r[3]  = 32'hFFFF_FFFB;
        vec_w[4]  = enc(SLL,  5'd16, 5'd11, 5'd11, 12'd0);  vec_r[4]  = 32'h0000_0018;
        vec_w[5]  = enc(SRL,  5'd17, 5'd10, 5'd11, 12'd0);  vec_r[5]  = 32'h1FFF_FFFF;
        vec_w[6]  = enc(SRA,  5'd18, 5'd10, 5'd11, 12'd0);  vec_r[6]  = 32'hFFFF_FFFF;
        vec_w[7]  = enc(SLT,  5'd19, 5'd10, 5'd11, 12'd0);  vec_r[7]  = 32'h0000_0001;
        vec_w[8]  = enc(XORI, 5'd20, 5'd11, 5'd0, 12'hFFF); vec_r[8]  = 32'hFFFF_FFFC;
        vec_w[9]  = enc(DIV,  5'd21, 5'd10, 5'd11, 12'd0);  vec_r[9]  = 32'h5555_5552;
        vec_w[10] = enc(SUB,  5'd22, 5'd11, 5'd10, 12'd0);  vec_r[10] = 32'h0000_000B;
        vec_w[11] = enc(ADD,  5'd23, 5'd10, 5'd11, 12'd0);  vec_r[11] = 32'hFFFF_FFFB;
        for (int i = 0; i < 12; i++) begin
            run(vec_w[i]);
            check($sformatf("vec%0d_wdata", i), done_log[$].wdata, vec_r[i]);
            check($sformatf("vec%0d_we", i), done_log[$].we, 1'b1);
        end
        run(enc(NOP, 5'd24, 5'd10, 5'd11, 12'd0));
        check("nop_we", done_log[$].we, 1'b0);
        run(enc(5'b01101, 5'd25, 5'd10, 5'd11, 12'd0));
        check("ill2_flag", done_log[$].ill, 1'b1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
